// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - register map and frame constants for the inertial sensor SPI responder
// Purpose: shared 7-bit register addresses, command bit position and frame lengths.
package inert_pkg;

  // Configuration registers (read back written value)
  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI   = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G  = 7'h11;
  localparam logic [6:0] ADDR_CTRL5    = 7'h14;

  // Sample data registers, low byte then high byte
  localparam logic [6:0] ADDR_ROLL_L   = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H   = 7'h25;
  localparam logic [6:0] ADDR_YAW_L    = 7'h26;
  localparam logic [6:0] ADDR_YAW_H    = 7'h27;
  localparam logic [6:0] ADDR_AY_L     = 7'h2A;
  localparam logic [6:0] ADDR_AY_H     = 7'h2B;
  localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

  // Bit 15 of the command word selects read (1) or write (0)
  localparam int CMD_RD = 15;

  // Frame is 16 SCLKs: 8-bit command byte then 8-bit data byte
  localparam logic [4:0] FRAME_LEN = 5'd16;
  localparam logic [4:0] CMD_LEN   = 5'd8;

endpackage

// File: rtl/inert_spi_resp_spi_edge_sync.sv
// rtl/inert_spi_resp_spi_edge_sync.sv - triple-flop synchronizer with rise/fall strobes
// Purpose: bring one asynchronous SPI pin into the clk domain and flag its edges.
// Ports: clk, rst_n (async active-low); d_i async input;
//        rise_o / fall_o one-clk strobes on the synchronized edge.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // ff_q[1] is the synchronized level; ff_q[2] is its one-clk-old copy
  logic [2:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {3{RST_VAL}};
    end else begin
      ff_q <= {ff_q[1:0], d_i};
    end
  end

  assign rise_o = ff_q[1] & ~ff_q[2];
  assign fall_o = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/inert_spi_resp.sv
// rtl/inert_spi_resp.sv - SPI responder emulating the inertial sensor
// Purpose: decode 16-bit SPI frames, hold config registers, serve sample data,
//          and raise a data-ready interrupt when a new sample is captured.
// Ports: clk, rst_n (async active-low); SS_n, SCLK, MOSI, MISO SPI link
//        (SCLK idles high, data sampled on rise); INT data-ready interrupt;
//        smpl_vld strobe with roll_rt_in, yaw_rt_in, AY_in, AZ_in samples.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0]  WHOAMI     = 8'h6A,
  parameter int unsigned INT_EN_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] roll_rt_in,
  input  logic [15:0] yaw_rt_in,
  input  logic [15:0] AY_in,
  input  logic [15:0] AZ_in
);

  logic        ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [1:0]  mosi_q;
  logic        ss_low_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] rx_q, rx_d;
  logic [7:0]  tx_q, rd_mux;
  logic [7:0]  int_ctrl_q, ctrl1_xl_q, ctrl2_g_q, ctrl5_q;
  logic [15:0] roll_q, yaw_q, ay_q, az_q;
  logic [15:0] roll_p_q, yaw_p_q, ay_p_q, az_p_q;
  logic        pend_q, lock_q, int_q, int_d;
  logic        frame_done, wr_commit, rd_roll_l, rd_az_h, int_set, int_clr;
  logic [6:0]  cmd_addr;

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // MOSI needs only the two-flop path; it is stable around synchronized SCLK rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= 2'b00;
    else        mosi_q <= {mosi_q[0], MOSI};
  end

  assign rx_d = {rx_q[14:0], mosi_q[1]};

  // Read mux addressed by the command byte as it completes (post-shift rx)
  always_comb begin
    rd_mux = 8'h00;
    case (rx_d[6:0])
      ADDR_INT_CTRL: rd_mux = int_ctrl_q;
      ADDR_WHOAMI:   rd_mux = WHOAMI;
      ADDR_CTRL1_XL: rd_mux = ctrl1_xl_q;
      ADDR_CTRL2_G:  rd_mux = ctrl2_g_q;
      ADDR_CTRL5:    rd_mux = ctrl5_q;
      ADDR_ROLL_L:   rd_mux = roll_q[7:0];
      ADDR_ROLL_H:   rd_mux = roll_q[15:8];
      ADDR_YAW_L:    rd_mux = yaw_q[7:0];
      ADDR_YAW_H:    rd_mux = yaw_q[15:8];
      ADDR_AY_L:     rd_mux = ay_q[7:0];
      ADDR_AY_H:     rd_mux = ay_q[15:8];
      ADDR_AZ_L:     rd_mux = az_q[7:0];
      ADDR_AZ_H:     rd_mux = az_q[15:8];
      default:       rd_mux = 8'h00;
    endcase
  end

  // Frame-level decode, evaluated on the SS_n rise that ends a frame
  assign cmd_addr   = rx_q[14:8];
  assign frame_done = ss_rise && (bit_cnt_q == FRAME_LEN);
  assign wr_commit  = frame_done && !rx_q[CMD_RD];
  assign rd_roll_l  = frame_done && rx_q[CMD_RD] && (cmd_addr == ADDR_ROLL_L);
  assign rd_az_h    = frame_done && rx_q[CMD_RD] && (cmd_addr == ADDR_AZ_H);

  // A fresh sample (direct or released from pending) beats any clear in the same clk
  assign int_set = !lock_q && (smpl_vld || pend_q) && int_ctrl_q[INT_EN_BIT];
  assign int_clr = rd_roll_l ||
                   (wr_commit && (cmd_addr == ADDR_INT_CTRL) && !rx_q[INT_EN_BIT]);
  assign int_d   = int_set || (int_q && !int_clr);

  // SPI shift engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_low_q  <= 1'b0;
      bit_cnt_q <= 5'd0;
      rx_q      <= 16'h0000;
      tx_q      <= 8'h00;
    end else if (ss_fall) begin
      ss_low_q  <= 1'b1;
      bit_cnt_q <= 5'd0;
      rx_q      <= 16'h0000;
      tx_q      <= 8'h00;
    end else if (ss_rise) begin
      ss_low_q  <= 1'b0;
    end else if (ss_low_q) begin
      if (sclk_rise) begin
        rx_q <= rx_d;
        if (bit_cnt_q != FRAME_LEN) bit_cnt_q <= bit_cnt_q + 5'd1;
        if (bit_cnt_q == CMD_LEN - 5'd1) tx_q <= rd_mux;
      end else if (sclk_fall && (bit_cnt_q > CMD_LEN)) begin
        // The fall right after the load keeps bit 7 on MISO for the 9th rise
        tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end

  // Configuration registers, sample capture, burst lock and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ctrl_q <= 8'h00;
      ctrl1_xl_q <= 8'h00;
      ctrl2_g_q  <= 8'h00;
      ctrl5_q    <= 8'h00;
      roll_q     <= 16'h0000;
      yaw_q      <= 16'h0000;
      ay_q       <= 16'h0000;
      az_q       <= 16'h0000;
      roll_p_q   <= 16'h0000;
      yaw_p_q    <= 16'h0000;
      ay_p_q     <= 16'h0000;
      az_p_q     <= 16'h0000;
      pend_q     <= 1'b0;
      lock_q     <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (cmd_addr)
          ADDR_INT_CTRL: int_ctrl_q <= rx_q[7:0];
          ADDR_CTRL1_XL: ctrl1_xl_q <= rx_q[7:0];
          ADDR_CTRL2_G:  ctrl2_g_q  <= rx_q[7:0];
          ADDR_CTRL5:    ctrl5_q    <= rx_q[7:0];
          default:       ;
        endcase
      end

      if (rd_roll_l)    lock_q <= 1'b1;
      else if (rd_az_h) lock_q <= 1'b0;

      // While a burst read is in progress the data registers are frozen so the
      // master sees one coherent sample; the newest arrival waits in pending.
      if (!lock_q) begin
        if (smpl_vld) begin
          roll_q <= roll_rt_in;
          yaw_q  <= yaw_rt_in;
          ay_q   <= AY_in;
          az_q   <= AZ_in;
        end else if (pend_q) begin
          roll_q <= roll_p_q;
          yaw_q  <= yaw_p_q;
          ay_q   <= ay_p_q;
          az_q   <= az_p_q;
        end
        pend_q <= 1'b0;
      end else if (smpl_vld) begin
        roll_p_q <= roll_rt_in;
        yaw_p_q  <= yaw_rt_in;
        ay_p_q   <= AY_in;
        az_p_q   <= AZ_in;
        pend_q   <= 1'b1;
      end

      int_q <= int_d;
    end
  end

  assign MISO = ss_low_q ? tx_q[7] : 1'b0;
  assign INT  = int_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// tb/tb_inert_spi_resp.sv - scoreboard testbench for inert_spi_resp
module tb_inert_spi_resp;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] roll_rt_in = 16'h0000;
  logic [15:0] yaw_rt_in = 16'h0000;
  logic [15:0] AY_in = 16'h0000;
  logic [15:0] AZ_in = 16'h0000;
  logic        MISO;
  logic        INT;

  int n_cmp = 0;
  int n_err = 0;

  string       name_q[$];
  logic [15:0] val_q[$];

  always #5 clk = ~clk;

  inert_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .smpl_vld(smpl_vld), .roll_rt_in(roll_rt_in), .yaw_rt_in(yaw_rt_in),
    .AY_in(AY_in), .AZ_in(AZ_in)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Master side of one frame; SCLK idles high, MOSI changes on SCLK fall
  task automatic xfer(input logic [15:0] cmd, input int nbits, input bit hold);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (!hold) begin
      SS_n = 1'b1;
      repeat (HALF + 2) @(negedge clk);
    end
  endtask

  task automatic wr(input logic [15:0] cmd);
    xfer(cmd, 16, 1'b0);
  endtask

  task automatic rd(input logic [15:0] cmd, input logic [7:0] exp, input string nm);
    name_q.push_back(nm);
    val_q.push_back({8'h00, exp});
    xfer(cmd, 16, 1'b0);
  endtask

  task automatic sample(input logic [15:0] r, input logic [15:0] y,
                        input logic [15:0] a, input logic [15:0] z);
    @(negedge clk);
    roll_rt_in = r;
    yaw_rt_in  = y;
    AY_in      = a;
    AZ_in      = z;
    smpl_vld   = 1'b1;
    @(negedge clk);
    smpl_vld   = 1'b0;
  endtask

  // Monitor: reassembles each frame from the pins and checks full read frames
  initial begin
    logic [15:0] mo, mi;
    int          n;
    string       nm;
    logic [15:0] ev;
    forever begin
      @(negedge SS_n);
      mo = 16'h0000;
      mi = 16'h0000;
      n  = 0;
      forever begin
        @(posedge SCLK or posedge SS_n);
        if (SS_n) break;
        mo = {mo[14:0], MOSI};
        mi = {mi[14:0], MISO};
        n++;
      end
      if (n == 16 && mo[15]) begin
        if (val_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: read frame %h returned %h with no expectation", mo, mi);
        end else begin
          nm = name_q.pop_front();
          ev = val_q.pop_front();
          chk(nm, mi, ev);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_miso", 16'(MISO), 16'h0000);
    chk("reset_int", 16'(INT), 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Config write / read-back
    wr(16'h0D02);
    wr(16'h1053);
    wr(16'h1150);
    wr(16'h1460);
    rd(16'h8D00, 8'h02, "rd_int_ctrl");
    rd(16'h9000, 8'h53, "rd_ctrl1_xl");
    rd(16'h9100, 8'h50, "rd_ctrl2_g");
    rd(16'h9400, 8'h60, "rd_ctrl5");
    rd(16'h8F00, 8'h6A, "rd_whoami");
    rd(16'hA800, 8'h00, "rd_unmapped");

    // Sample capture and burst lock
    sample(16'h1234, 16'hABCD, 16'h0F0F, 16'h8001);
    chk("int_set", 16'(INT), 16'h0001);
    rd(16'hA400, 8'h34, "rd_roll_l");
    chk("int_clr_roll_l", 16'(INT), 16'h0000);
    rd(16'hA500, 8'h12, "rd_roll_h");
    sample(16'h5566, 16'h7788, 16'h99AA, 16'hBBCC);
    chk("int_locked", 16'(INT), 16'h0000);
    rd(16'hA600, 8'hCD, "rd_yaw_l");
    rd(16'hA700, 8'hAB, "rd_yaw_h");
    rd(16'hAA00, 8'h0F, "rd_ay_l");
    rd(16'hAB00, 8'h0F, "rd_ay_h");
    rd(16'hAC00, 8'h01, "rd_az_l");
    rd(16'hAD00, 8'h80, "rd_az_h");
    chk("int_after_unlock", 16'(INT), 16'h0001);
    rd(16'hA400, 8'h66, "rd_pend_roll_l");
    rd(16'hA500, 8'h55, "rd_pend_roll_h");
    rd(16'hA600, 8'h88, "rd_pend_yaw_l");
    rd(16'hAD00, 8'hBB, "rd_pend_az_h");
    chk("int_clr_second", 16'(INT), 16'h0000);

    // Aborted write after 9 SCLKs
    xfer(16'h10FF, 9, 1'b0);
    rd(16'h9000, 8'h53, "rd_after_abort");
    chk("int_after_abort", 16'(INT), 16'h0000);

    // INT disable by writing INT_CTRL
    sample(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    chk("int_set_again", 16'(INT), 16'h0001);
    wr(16'h0D00);
    chk("int_clr_by_ctrl", 16'(INT), 16'h0000);
    sample(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    chk("int_disabled", 16'(INT), 16'h0000);
    rd(16'hA400, 8'h02, "rd_dis_roll_l");
    rd(16'hAA00, 8'h06, "rd_dis_ay_l");
    rd(16'hAD00, 8'h07, "rd_dis_az_h");
    rd(16'h8D00, 8'h00, "rd_int_ctrl_zero");

    // Reset in the middle of a read frame
    wr(16'h0D02);
    sample(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    chk("int_pre_reset", 16'(INT), 16'h0001);
    xfer(16'h8F00, 10, 1'b1);
    chk("miso_mid_frame", 16'(MISO), 16'h0001);
    rst_n = 1'b0;
    #2;
    chk("miso_in_reset", 16'(MISO), 16'h0000);
    chk("int_in_reset", 16'(INT), 16'h0000);
    @(negedge clk);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(16'h8D00, 8'h00, "rst_int_ctrl");
    rd(16'h9000, 8'h00, "rst_ctrl1_xl");
    rd(16'h9400, 8'h00, "rst_ctrl5");
    rd(16'hA400, 8'h00, "rst_roll_l");
    rd(16'hAD00, 8'h00, "rst_az_h");
    rd(16'h8F00, 8'h6A, "rst_whoami");
    chk("int_after_reset", 16'(INT), 16'h0000);

    repeat (20) @(negedge clk);
    chk("sb_drain", 16'(name_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
